reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Two-requester register-bus arbiter: alternating priority on ties, one-hot register select.
// Define REG_ARB_TIMEOUT_EN to bound the wait for reg_ready by TIMEOUT_CYCLES.
module reg_bus_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,

    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,

    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,

    output logic [NUM_REGS-1:0]   reg_enable,
    output logic                  reg_write,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [NUM_REGS-1:0]   reg_ready,
    input  logic [DATA_WIDTH-1:0] reg_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]      r_tmo;
`endif

    logic [1:0]            r_state;
    logic                  r_last;   // 1: req1 was granted most recently
    logic                  r_gnt;    // requester owning the current access

    logic                  w_pick1;
    logic                  w_write;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [NUM_REGS-1:0]   w_onehot;
    logic                  w_addr_ok;
    logic                  w_ready;

    assign w_pick1 = req1_valid & (~req0_valid | ~r_last);
    assign w_write = w_pick1 ? req1_write : req0_write;
    assign w_addr  = w_pick1 ? req1_addr  : req0_addr;
    assign w_wdata = w_pick1 ? req1_wdata : req0_wdata;

    // An out-of-range address decodes to no select bit, which doubles as the range check.
    always_comb begin
        w_onehot = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_onehot[i] = (w_addr == ADDR_WIDTH'(i));
        end
    end

    assign w_addr_ok = |w_onehot;
    assign w_ready   = |(reg_ready & reg_enable);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            reg_enable <= '0;
            reg_write  <= 1'b0;
            reg_wdata  <= '0;
            req0_done  <= 1'b0;
            req0_err   <= 1'b0;
            req0_rdata <= '0;
            req1_done  <= 1'b0;
            req1_err   <= 1'b0;
            req1_rdata <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            r_tmo      <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        r_gnt     <= w_pick1;
                        reg_wdata <= w_wdata;
`ifdef REG_ARB_TIMEOUT_EN
                        r_tmo     <= '0;
`endif
                        if (w_addr_ok) begin
                            reg_enable <= w_onehot;
                            reg_write  <= w_write;
                            r_state    <= ST_ACCESS;
                        end else begin
                            if (w_pick1) begin
                                req1_done <= 1'b1;
                                req1_err  <= 1'b1;
                            end else begin
                                req0_done <= 1'b1;
                                req0_err  <= 1'b1;
                            end
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (w_ready) begin
                        reg_enable <= '0;
                        reg_write  <= 1'b0;
                        if (r_gnt) begin
                            req1_done  <= 1'b1;
                            req1_err   <= 1'b0;
                            req1_rdata <= reg_rdata;
                        end else begin
                            req0_done  <= 1'b1;
                            req0_err   <= 1'b0;
                            req0_rdata <= reg_rdata;
                        end
                        r_state <= ST_DONE;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        reg_enable <= '0;
                        reg_write  <= 1'b0;
                        if (r_gnt) begin
                            req1_done <= 1'b1;
                            req1_err  <= 1'b1;
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    req0_done  <= 1'b0;
                    req0_err   <= 1'b0;
                    req0_rdata <= '0;
                    req1_done  <= 1'b0;
                    req1_err   <= 1'b0;
                    req1_rdata <= '0;
                    r_last     <= r_gnt;
                    r_state    <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed vector table, corner sequences, random traffic.
// Honours REG_ARB_TIMEOUT_EN for the never-ready scenario.
module tb_reg_bus_arbiter;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 4;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          req0_valid, req0_write, req1_valid, req1_write;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_done, req0_err, req1_done, req1_err;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic [NR-1:0] reg_enable;
    logic          reg_write;
    logic [DW-1:0] reg_wdata;
    logic [NR-1:0] reg_ready;
    logic [DW-1:0] reg_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [DW-1:0] env_regs [NR];   // register slaves seen by the DUT
    logic [DW-1:0] ref_regs [NR];   // expected register contents
    int            ref_last;        // requester granted most recently

    reg_bus_arbiter #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .reg_enable(reg_enable), .reg_write(reg_write), .reg_wdata(reg_wdata),
        .reg_ready(reg_ready), .reg_rdata(reg_rdata)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one request pair, plays the register slave, and reports the observed completion.
    task automatic run_txn(
        input  logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input  logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input  int rdly, input int budget,
        output int who, output logic [DW-1:0] rd, output logic er, output int lat,
        output logic en_seen);
        int            en_cycles;
        logic          commit;
        int            idx;
        int            cidx;
        logic [DW-1:0] cdata;
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
        reg_ready = '0;
        who = -1; rd = '0; er = 1'b0; lat = 0; en_seen = 1'b0;
        en_cycles = 0; commit = 1'b0; idx = 0; cidx = 0; cdata = '0;
        for (int c = 1; c <= budget && who < 0; c++) begin
            @(negedge clk_in);
            if (commit) begin
                env_regs[cidx] = cdata;
                commit = 1'b0;
            end
            chk("enable_onehot0", 64'($onehot0(reg_enable)), 64'd1);
            chk("single_done", 64'(req0_done & req1_done), 64'd0);
            if (req0_done || req1_done) begin
                who = req1_done ? 1 : 0;
                lat = c;
                rd  = req1_done ? req1_rdata : req0_rdata;
                er  = req1_done ? req1_err : req0_err;
                chk("loser_quiet", who == 1 ? 64'({req0_rdata, req0_err}) : 64'({req1_rdata, req1_err}), 64'd0);
                chk("enable_clear_at_done", 64'(reg_enable), 64'd0);
                reg_ready = '0;
            end else if (reg_enable != '0) begin
                en_seen = 1'b1;
                for (int i = 0; i < NR; i++) if (reg_enable[i]) idx = i;
                reg_rdata = env_regs[idx];
                if (en_cycles >= rdly) begin
                    reg_ready = reg_enable;
                    if (reg_write) begin
                        commit = 1'b1;
                        cidx   = idx;
                        cdata  = reg_wdata;
                    end
                end
                en_cycles++;
            end
        end
        chk("done_within_budget", 64'(who >= 0), 64'd1);
        @(negedge clk_in);
        chk("done_clears", 64'({req0_done, req1_done, req0_err, req1_err}), 64'd0);
        chk("rdata_clears", {req0_rdata, req1_rdata}, 64'd0);
    endtask

    // Transaction-level reference: grant rule, range check, register file contents.
    task automatic model_txn(
        input string tag,
        input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input int rdly);
        int            who, lat, ew;
        logic [DW-1:0] rd, ed, erd;
        logic          er, en_seen, ewr, bad;
        int            ea;
        run_txn(v0, w0, a0, d0, v1, w1, a1, d1, rdly, 40, who, rd, er, lat, en_seen);
        ew  = (v0 && v1) ? 1 - ref_last : (v1 ? 1 : 0);
        ea  = (ew == 1) ? int'(a1) : int'(a0);
        ed  = (ew == 1) ? d1 : d0;
        ewr = (ew == 1) ? w1 : w0;
        bad = (ea >= NR);
        erd = bad ? '0 : ref_regs[ea];
        chk({tag, "_winner"}, 64'(who), 64'(ew));
        chk({tag, "_err"}, 64'(er), 64'(bad));
        chk({tag, "_rdata"}, 64'(rd), 64'(erd));
        if (bad) begin
            chk({tag, "_no_enable"}, 64'(en_seen), 64'd0);
            chk({tag, "_err_latency"}, 64'(lat >= 1 && lat <= 2), 64'd1);
        end else begin
            chk({tag, "_latency"}, 64'(lat), 64'(2 + rdly));
            if (ewr) ref_regs[ea] = ed;
        end
        ref_last = ew;
    endtask

    typedef struct {
        logic v0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic v1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        int rdly; int who; logic err; logic [DW-1:0] rdata;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int            who, lat, n_done;
        logic [DW-1:0] rd;
        logic          er, en_seen;
        logic          v0, v1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        int            sel;

        tbl[0]  = '{1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 32'h0,        0, 0, 1'b0, 32'h33333333};
        tbl[1]  = '{1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0, 4'd3, 32'h0,        0, 1, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b0, 4'd1, 32'h0,        1'b1, 1'b1, 4'd2, 32'hCAFE0002, 1, 0, 1'b0, 32'h11111111};
        tbl[3]  = '{1'b1, 1'b0, 4'd1, 32'h0,        1'b1, 1'b1, 4'd2, 32'hCAFE0002, 1, 1, 1'b0, 32'h22222222};
        tbl[4]  = '{1'b1, 1'b0, 4'd1, 32'h0,        1'b1, 1'b1, 4'd2, 32'hCAFE0002, 1, 0, 1'b0, 32'h11111111};
        tbl[5]  = '{1'b1, 1'b0, 4'd9, 32'h0,        1'b0, 1'b0, 4'd0, 32'h0,        0, 0, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0, 4'd2, 32'h0,        3, 1, 1'b0, 32'hCAFE0002};
        tbl[7]  = '{1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0, 4'd15, 32'h0,       0, 1, 1'b1, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 4'd7, 32'h0,        1'b1, 1'b0, 4'd0, 32'h0,        0, 0, 1'b0, 32'h77777777};
        tbl[9]  = '{1'b1, 1'b1, 4'd0, 32'h0BADF00D, 1'b0, 1'b0, 4'd0, 32'h0,        2, 0, 1'b0, 32'h00000000};
        tbl[10] = '{1'b1, 1'b0, 4'd4, 32'h0,        1'b1, 1'b0, 4'd0, 32'h0,        0, 1, 1'b0, 32'h0BADF00D};

        for (int i = 0; i < NR; i++) begin
            env_regs[i] = {8{4'(i)}};
            ref_regs[i] = {8{4'(i)}};
        end
        ref_last = 1;

        rst_n_in = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        reg_ready = '0; reg_rdata = '0;
        repeat (2) @(negedge clk_in);
        chk("reset_enable", 64'(reg_enable), 64'd0);
        chk("reset_write", 64'(reg_write), 64'd0);
        chk("reset_wdata", 64'(reg_wdata), 64'd0);
        chk("reset_done_err", 64'({req0_done, req1_done, req0_err, req1_err}), 64'd0);
        chk("reset_rdata", {req0_rdata, req1_rdata}, 64'd0);
        rst_n_in = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                    tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1,
                    tbl[i].rdly, 40, who, rd, er, lat, en_seen);
            chk($sformatf("vec%0d_winner", i), 64'(who), 64'(tbl[i].who));
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(tbl[i].err));
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(tbl[i].rdata));
            if (tbl[i].err) begin
                chk($sformatf("vec%0d_no_enable", i), 64'(en_seen), 64'd0);
            end else begin
                chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(2 + tbl[i].rdly));
                if (tbl[i].who == 1 && tbl[i].w1) ref_regs[tbl[i].a1] = tbl[i].d1;
                if (tbl[i].who == 0 && tbl[i].w0) ref_regs[tbl[i].a0] = tbl[i].d0;
            end
            ref_last = tbl[i].who;
        end

        // Reset in the middle of an access: enable drops at once, no completion pulse.
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 4'd4; req0_wdata = '0;
        req1_valid = 1'b0; reg_ready = '0;
        repeat (3) @(negedge clk_in);
        chk("midrst_enable_before", 64'(reg_enable), 64'h10);
        #2 rst_n_in = 1'b0;
        #1;
        chk("midrst_enable_async", 64'(reg_enable), 64'd0);
        chk("midrst_done_async", 64'({req0_done, req1_done}), 64'd0);
        repeat (2) @(negedge clk_in);
        chk("midrst_done_held", 64'({req0_done, req1_done, reg_write}), 64'd0);
        rst_n_in = 1'b1;
        ref_last = 1;
        model_txn("post_rst", 1'b1, 1'b0, 4'd4, '0, 1'b0, 1'b0, 4'd0, '0, 0);
        model_txn("post_rst_tie", 1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd6, '0, 1);

        // A register that never answers.
`ifdef REG_ARB_TIMEOUT_EN
        run_txn(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd5, '0, 1000, 40, who, rd, er, lat, en_seen);
        chk("tmo_winner", 64'(who), 64'd1);
        chk("tmo_err", 64'(er), 64'd1);
        chk("tmo_rdata", 64'(rd), 64'd0);
        chk("tmo_latency", 64'(lat), 64'd17);
        ref_last = 1;
`else
        req0_valid = 1'b0; req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 4'd5; reg_ready = '0;
        n_done = 0;
        repeat (110) begin
            @(negedge clk_in);
            if (req0_done || req1_done) n_done++;
        end
        chk("hold_enable", 64'(reg_enable), 64'h20);
        chk("hold_no_done", 64'(n_done), 64'd0);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        req1_valid = 1'b0;
        rst_n_in = 1'b1;
        ref_last = 1;
`endif

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(1, 3);
            v0 = sel[0]; v1 = sel[1];
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            a0 = AW'($urandom_range(0, 10)); a1 = AW'($urandom_range(0, 10));
            d0 = $urandom; d1 = $urandom;
            model_txn($sformatf("rnd%0d", n), v0, w0, a0, d0, v1, w1, a1, d1, $urandom_range(0, 3));
        end

        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
